plic_gateway: RTL and testbench
===============================

# plic_gateway

Interrupt gateway in front of the SoC PLIC core. Converts raw peripheral interrupt lines into per-source pending requests and tracks each request through claim and completion. Queues edge-triggered events that arrive while a source is busy, using a saturating per-source counter. Sits between peripheral IRQ outputs (UART1, SPI, GPIO, ...) and the PLIC priority/threshold logic, which consumes `o_pending` and issues claim/complete.

## Interface

Parameters:
- `irqmax`, default `CFG_PLIC_IRQ_TOTAL` (73): number of sources including reserved source 0.

Ports (clock and reset first):
- `i_clk`, input, 1: system clock. One clock domain.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_irq`, input, irqmax: raw interrupt lines. Bit 0 is ignored.
- `i_edge_mode`, input, irqmax: per-source trigger mode; 1 = rising edge, 0 = level-high.
- `o_pending`, output, irqmax: registered pending requests to the PLIC core. Bit 0 is always 0.
- `i_claim_valid`, input, 1: claim strobe.
- `i_claim_id`, input, 10: ID of the source being claimed.
- `i_complete_valid`, input, 1: completion strobe.
- `i_complete_id`, input, 10: ID of the source being completed.
- `o_claimed`, output, irqmax: registered; source is claimed and awaiting completion.
- `o_overflow`, output, irqmax: sticky; an edge was lost because the counter was saturated.

## Operation

- Each source n (1..irqmax-1) has an FSM with states IDLE, PEND and CLAIMED.
  - It also has a 3-bit saturating counter `cnt` (0..7) and a registered sample `irq_q`.
- Edge detect: `edge = i_irq[n] & ~irq_q`.
- Trigger:
  - `trig = edge` in edge mode.
  - `trig = i_irq[n]` in level mode.
- Transitions:
  - IDLE, trig → PEND.
  - PEND, claim hit → CLAIMED.
  - CLAIMED, complete hit, cnt = 0 → IDLE.
  - CLAIMED, complete hit, cnt > 0 → PEND, cnt − 1.
- Claim hit: `i_claim_valid`, `i_claim_id == n`, and the state is PEND.
- Complete hit: `i_complete_valid`, `i_complete_id == n`, and the state is CLAIMED.
- Hit qualification:
  - A claim for a source not in PEND is ignored, with no state change.
  - A complete for a source not in CLAIMED is ignored.
  - ID 0 and IDs ≥ irqmax are ignored for both claim and complete.
- Edge mode, edge in PEND or CLAIMED:
  - cnt < 7: cnt + 1.
  - cnt = 7: cnt stays at 7 and `o_overflow[n]` sets.
- Level mode:
  - cnt is forced to 0.
  - Deassertion of `i_irq` while in PEND does not retract the pending request. It stays PEND until claimed.
  - After completion, a still-high level re-pends the source on the next evaluation from IDLE.
- Simultaneous events on the same source:
  - Edge and complete hit in the same cycle: the increment and the decrement cancel. Next state is PEND, cnt unchanged.
  - Claim and complete for the same ID in the same cycle: only the one matching the current state applies.
  - Claim and complete for different IDs in the same cycle: both apply.
- `i_edge_mode` change: takes effect in the cycle it changes. Switching to level clears cnt. It does not alter the FSM state.
- Reset:
  - All FSMs go to IDLE; cnt = 0 and `irq_q` = 0.
  - `o_pending`, `o_claimed` and `o_overflow` = 0.
  - Reset mid-claim discards the claim; the PLIC side resets together.
  - A line already high at reset release, in edge mode, is seen as an edge in the first cycle after reset.
- `o_overflow` clears only by reset.

## Timing

- `i_irq` rising at sample edge N → `o_pending[n]` = 1 after clock edge N+1 (1-cycle latency), both modes.
- Claim strobe at edge N → `o_pending[n]` = 0 and `o_claimed[n]` = 1 after edge N+1.
- Complete at edge N:
  - cnt = 0 → `o_claimed[n]` = 0 after N+1.
  - cnt > 0 → `o_claimed[n]` = 0 and `o_pending[n]` = 1 after N+1.
- Minimum IDLE time after completion, level mode: 1 cycle before re-pend.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Add to `riscv_soc_pkg`:
  - The state enum type `plic_gw_state_type` {IDLE, PEND, CLAIMED}.
  - `CFG_PLIC_GW_CNT_WIDTH = 3`.
  - `CFG_PLIC_ID_WIDTH = 10`.
- Sub-module `plic_gateway_src`: one source's FSM, counter and edge detector.
  - Inputs: `claim_hit`, `complete_hit`.
  - Outputs: pending, claimed, overflow.
  - Instantiated by `generate` for n = 1..irqmax-1.
- The top level contains only ID decode and output bus assembly, with bit 0 tied to 0.

## Test plan

- Level mode: hold `i_irq[11]` = 1, claim ID 11, then complete 11 → pending at +1, claimed at claim+1, re-pend at complete+2.
- Edge mode, 3 pulses on source 12 during CLAIMED:
  - cnt = 3.
  - Each complete yields PEND again; after the 4th complete, IDLE.
- Edge mode, 9 pulses while CLAIMED: cnt = 7 and `o_overflow[12]` = 1. After 8 completes, the source is IDLE with no further pend.
- Same cycle: edge on source 5 plus complete 5 with cnt = 2 → next state PEND, cnt = 2.
- Bad IDs:
  - Claim ID 0, claim ID 73, and complete of an IDLE source → no output change.
  - Simultaneous claim 3 and complete 7 → both take effect.
- Reset asserted while source 9 is CLAIMED with cnt = 4 → all outputs 0 next cycle. An edge-mode line held high yields pending 1 cycle after release.

Source files
------------

// File: rtl/riscv_soc_pkg.sv
// Shared SoC definitions: PLIC sizing and interrupt gateway types.
package riscv_soc_pkg;

    localparam int unsigned CFG_PLIC_IRQ_TOTAL    = 73;
    localparam int unsigned CFG_PLIC_GW_CNT_WIDTH = 3;
    localparam int unsigned CFG_PLIC_ID_WIDTH     = 10;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        CLAIMED
    } plic_gw_state_type;

endpackage

// File: rtl/plic_gateway_src.sv
// One interrupt source: edge detector, IDLE/PEND/CLAIMED tracker and a saturating
// counter of edges queued while the source is busy.
module plic_gateway_src
    import riscv_soc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic edge_mode,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending,
    output logic claimed,
    output logic overflow
);

    localparam logic [CFG_PLIC_GW_CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CFG_PLIC_GW_CNT_WIDTH-1:0] CntOne = CFG_PLIC_GW_CNT_WIDTH'(1);

    plic_gw_state_type                state_q, state_d;
    logic [CFG_PLIC_GW_CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_eff;
    logic                             irq_q;
    logic                             ovf_q, ovf_d;
    logic                             edge_det, trig, queue_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        edge_det   = irq & ~irq_q;
        trig       = edge_mode ? edge_det : irq;
        // A mode switch to level discards queued edges in the same cycle.
        cnt_eff    = edge_mode ? cnt_q : '0;
        state_d    = state_q;
        cnt_d      = cnt_eff;
        ovf_d      = ovf_q;
        queue_edge = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trig) state_d = PEND;
            end
            PEND: begin
                if (claim_hit) state_d = CLAIMED;
                queue_edge = edge_mode & edge_det;
            end
            CLAIMED: begin
                if (complete_hit) begin
                    // A new edge arriving with completion replaces the dequeued one.
                    if (edge_mode & edge_det) begin
                        state_d = PEND;
                    end else if (cnt_eff != '0) begin
                        state_d = PEND;
                        cnt_d   = cnt_eff - CntOne;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    queue_edge = edge_mode & edge_det;
                end
            end
            default: state_d = IDLE;
        endcase

        if (queue_edge) begin
            if (cnt_eff == CntMax) ovf_d = 1'b1;
            else                   cnt_d = cnt_eff + CntOne;
        end
    end

    assign pending  = (state_q == PEND);
    assign claimed  = (state_q == CLAIMED);
    assign overflow = ovf_q;

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: decodes claim/complete IDs and assembles per-source status buses.
module plic_gateway
    import riscv_soc_pkg::*;
#(
    parameter int unsigned irqmax = CFG_PLIC_IRQ_TOTAL
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [irqmax-1:0]            i_irq,
    input  logic [irqmax-1:0]            i_edge_mode,
    output logic [irqmax-1:0]            o_pending,
    input  logic                         i_claim_valid,
    input  logic [CFG_PLIC_ID_WIDTH-1:0] i_claim_id,
    input  logic                         i_complete_valid,
    input  logic [CFG_PLIC_ID_WIDTH-1:0] i_complete_id,
    output logic [irqmax-1:0]            o_claimed,
    output logic [irqmax-1:0]            o_overflow
);

    // Source 0 is reserved and has no gateway.
    logic unused_bit0;
    assign unused_bit0   = i_irq[0] | i_edge_mode[0];
    assign o_pending[0]  = 1'b0;
    assign o_claimed[0]  = 1'b0;
    assign o_overflow[0] = 1'b0;

    for (genvar n = 1; n < int'(irqmax); n++) begin : g_src
        logic claim_hit, complete_hit;

        assign claim_hit    = i_claim_valid &&
                              (i_claim_id == CFG_PLIC_ID_WIDTH'(n));
        assign complete_hit = i_complete_valid &&
                              (i_complete_id == CFG_PLIC_ID_WIDTH'(n));

        plic_gateway_src u_src (
            .clk          (i_clk),
            .rst          (i_rst),
            .irq          (i_irq[n]),
            .edge_mode    (i_edge_mode[n]),
            .claim_hit    (claim_hit),
            .complete_hit (complete_hit),
            .pending      (o_pending[n]),
            .claimed      (o_claimed[n]),
            .overflow     (o_overflow[n])
        );
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: directed scenarios plus random traffic
// against a per-source request-tracking model.
module tb_plic_gateway;

    localparam int N = 73;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq, mode;
    logic [N-1:0] pending, claimed, overflow;
    logic         claim_valid, complete_valid;
    logic [9:0]   claim_id, complete_id;

    int total = 0;
    int bad   = 0;

    // Model: 0 = idle, 1 = pending, 2 = claimed; queued = extra edges owed.
    int m_st[N];
    int m_cnt[N];
    bit m_q[N];
    bit m_ovf[N];

    always #5 clk = ~clk;

    plic_gateway #(.irqmax(N)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_irq            (irq),
        .i_edge_mode      (mode),
        .o_pending        (pending),
        .i_claim_valid    (claim_valid),
        .i_claim_id       (claim_id),
        .i_complete_valid (complete_valid),
        .i_complete_id    (complete_id),
        .o_claimed        (claimed),
        .o_overflow       (overflow)
    );

    task automatic model_step();
        bit e, tr, ch, co, ev;
        int c;
        for (int n = 0; n < N; n++) begin
            if (rst || n == 0) begin
                m_st[n] = 0; m_cnt[n] = 0; m_q[n] = 0; m_ovf[n] = 0;
            end else begin
                e  = irq[n] && !m_q[n];
                tr = mode[n] ? e : irq[n];
                ch = claim_valid && (int'(claim_id) == n);
                co = complete_valid && (int'(complete_id) == n);
                ev = mode[n] && e;
                c  = mode[n] ? m_cnt[n] : 0;
                case (m_st[n])
                    0: if (tr) m_st[n] = 1;
                    1: begin
                        if (ch) m_st[n] = 2;
                        if (ev) begin
                            if (c < 7) c++; else m_ovf[n] = 1;
                        end
                    end
                    default: begin
                        if (co) begin
                            if (ev)         m_st[n] = 1;
                            else if (c > 0) begin c--; m_st[n] = 1; end
                            else            m_st[n] = 0;
                        end else if (ev) begin
                            if (c < 7) c++; else m_ovf[n] = 1;
                        end
                    end
                endcase
                m_cnt[n] = c;
                m_q[n]   = irq[n];
            end
        end
    endtask

    task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic lit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        logic [N-1:0] ep, ec, eo;
        for (int n = 0; n < N; n++) begin
            ep[n] = (m_st[n] == 1);
            ec[n] = (m_st[n] == 2);
            eo[n] = m_ovf[n];
        end
        cmp("pending", pending, ep);
        cmp("claimed", claimed, ec);
        cmp("overflow", overflow, eo);
    endtask

    // One clock: model advances on the same edge, outputs checked 1ns later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
    endtask

    task automatic claim(input int id);
        claim_valid = 1'b1; claim_id = 10'(id);
    endtask

    task automatic complete(input int id);
        complete_valid = 1'b1; complete_id = 10'(id);
    endtask

    task automatic pulse(input int n);
        irq[n] = 1'b1; cyc();
        irq[n] = 1'b0; cyc();
    endtask

    int pick;

    initial begin
        rst = 1'b1; irq = '0; mode = '0;
        claim_valid = 1'b0; complete_valid = 1'b0; claim_id = '0; complete_id = '0;
        cyc(); cyc();
        cmp("rst_pending", pending, '0);
        cmp("rst_claimed", claimed, '0);
        rst = 1'b0;

        // Level source 11 held high.
        irq[11] = 1'b1; cyc();
        lit("lvl_pend", pending[11], 1'b1);
        claim(11); cyc();
        lit("lvl_claimed", claimed[11], 1'b1);
        lit("lvl_unpend", pending[11], 1'b0);
        complete(11); cyc();
        lit("lvl_idle_cl", claimed[11], 1'b0);
        lit("lvl_idle_pd", pending[11], 1'b0);
        cyc();
        lit("lvl_repend", pending[11], 1'b1);
        claim(11); cyc();
        irq[11] = 1'b0; complete(11); cyc(); cyc();
        lit("lvl_low_idle", pending[11], 1'b0);

        // Edge source 12: three queued pulses, four completions.
        mode[12] = 1'b1;
        pulse(12);
        lit("edge_pend", pending[12], 1'b1);
        claim(12); cyc();
        for (int k = 0; k < 3; k++) pulse(12);
        for (int k = 0; k < 4; k++) begin
            complete(12); cyc();
            lit("edge_cpl_cl", claimed[12], 1'b0);
            lit("edge_cpl_pd", pending[12], (k < 3) ? 1'b1 : 1'b0);
            if (k < 3) begin claim(12); cyc(); end
        end

        // Nine pulses while claimed saturate the counter.
        pulse(12);
        claim(12); cyc();
        for (int k = 0; k < 9; k++) pulse(12);
        lit("ovf_set", overflow[12], 1'b1);
        for (int k = 0; k < 8; k++) begin
            complete(12); cyc();
            lit("ovf_cpl_pd", pending[12], (k < 7) ? 1'b1 : 1'b0);
            if (k < 7) begin claim(12); cyc(); end
        end
        cyc(); cyc();
        lit("ovf_drained", pending[12], 1'b0);
        lit("ovf_sticky", overflow[12], 1'b1);

        // Source 5: edge coincident with completion, cnt = 2.
        mode[5] = 1'b1;
        pulse(5);
        claim(5); cyc();
        pulse(5); pulse(5);
        irq[5] = 1'b1; complete(5); cyc();
        lit("same_cyc_pd", pending[5], 1'b1);
        irq[5] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            claim(5); cyc();
            complete(5); cyc();
            lit("same_cyc_drain", pending[5], (k < 2) ? 1'b1 : 1'b0);
        end

        // Bad IDs and concurrent claim/complete on different sources.
        irq[3] = 1'b1; mode[7] = 1'b1;
        pulse(7);
        claim(7); cyc();
        claim(0); cyc();
        lit("bad_id0", pending[3], 1'b1);
        claim(73); cyc();
        lit("bad_id73", pending[3], 1'b1);
        complete(20); cyc();
        lit("idle_cpl", claimed[20], 1'b0);
        claim(3); complete(7); cyc();
        lit("dual_claim", claimed[3], 1'b1);
        lit("dual_cpl", claimed[7], 1'b0);
        irq[3] = 1'b0; complete(3); cyc();

        // Reset while source 9 is claimed with four queued edges.
        mode[9] = 1'b1;
        pulse(9);
        claim(9); cyc();
        for (int k = 0; k < 4; k++) pulse(9);
        irq[9] = 1'b1; rst = 1'b1; cyc();
        cmp("rst_mid_pd", pending, '0);
        cmp("rst_mid_cl", claimed, '0);
        cmp("rst_mid_ov", overflow, '0);
        rst = 1'b0; cyc();
        lit("rst_edge_pd", pending[9], 1'b1);

        // Random traffic.
        for (int cy = 0; cy < 4000; cy++) begin
            for (int n = 0; n < N; n++) begin
                if ($urandom_range(5) == 0)  irq[n] = ~irq[n];
                if ($urandom_range(60) == 0) mode[n] = $urandom_range(1);
            end
            rst = ($urandom_range(700) == 0);
            if ($urandom_range(1) == 1) begin
                pick = $urandom_range(80);
                if ($urandom_range(3) != 0) begin
                    for (int s = 0, b = $urandom_range(N - 2); s < N - 1; s++)
                        if (m_st[1 + (b + s) % (N - 1)] == 1) begin
                            pick = 1 + (b + s) % (N - 1);
                            break;
                        end
                end
                claim(pick);
            end
            if ($urandom_range(1) == 1) begin
                pick = $urandom_range(80);
                if ($urandom_range(3) != 0) begin
                    for (int s = 0, b = $urandom_range(N - 2); s < N - 1; s++)
                        if (m_st[1 + (b + s) % (N - 1)] == 2) begin
                            pick = 1 + (b + s) % (N - 1);
                            break;
                        end
                end
                complete(pick);
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
